// File: rtl/rca_nibble_seq_ctrl.sv
// Nibble-serial adder controller: drives one external combinational 4-bit RCA slice
// for WIDTH/4 cycles and returns {cout,sum} = a + b + cin over valid/ready handshakes.
module rca_nibble_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [3:0]       rca_a,
  output logic [3:0]       rca_b,
  output logic             rca_cin,
  input  logic [3:0]       rca_sum,
  input  logic             rca_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int IW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_sum;
  logic [IW-1:0]    r_idx;
  logic             r_carry, r_cout;
  logic             w_accept, w_last;
  logic [IW+1:0]    w_base;

  assign w_base   = {r_idx, 2'b00};
  assign w_accept = in_valid & (r_state == S_IDLE);
  assign w_last   = (r_idx == IW'(NIBBLES - 1));
  assign sum      = r_sum;
  assign cout     = r_cout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    rca_a     = 4'h0;
    rca_b     = 4'h0;
    rca_cin   = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = S_RUN;
      end
      S_RUN: begin
        busy    = 1'b1;
        rca_a   = r_a[w_base +: 4];
        rca_b   = r_b[w_base +: 4];
        rca_cin = r_carry;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Slice result is captured the same cycle it is driven; no pipeline stage in the loop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= cin;
      r_cout  <= 1'b0;
    end else if (r_state == S_RUN) begin
      r_sum[w_base +: 4] <= rca_sum;
      r_carry            <= rca_cout;
      r_idx              <= w_last ? '0 : r_idx + 1'b1;
      if (w_last) r_cout <= rca_cout;
    end
  end

endmodule

// File: tb/tb_rca_nibble_seq_ctrl.sv
// Bench for rca_nibble_seq_ctrl: WIDTH=16 and WIDTH=4 instances, each paired with a 4-bit slice.
module tb_rca_nibble_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=16 instance
  logic        in_valid = 1'b0, in_ready, cin = 1'b0, rca_cin, rca_cout, out_valid, out_ready = 1'b0, cout, busy;
  logic [15:0] a = '0, b = '0, sum;
  logic [3:0]  rca_a, rca_b, rca_sum;
  assign {rca_cout, rca_sum} = 5'(rca_a) + 5'(rca_b) + 5'(rca_cin);

  rca_nibble_seq_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .cin(cin),
    .rca_a(rca_a), .rca_b(rca_b), .rca_cin(rca_cin), .rca_sum(rca_sum), .rca_cout(rca_cout),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .busy(busy));

  // WIDTH=4 instance
  logic       in_valid4 = 1'b0, in_ready4, cin4 = 1'b0, rca_cin4, rca_cout4, out_valid4, out_ready4 = 1'b0, cout4, busy4;
  logic [3:0] a4 = '0, b4 = '0, sum4, rca_a4, rca_b4, rca_sum4;
  assign {rca_cout4, rca_sum4} = 5'(rca_a4) + 5'(rca_b4) + 5'(rca_cin4);

  rca_nibble_seq_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4), .a(a4), .b(b4), .cin(cin4),
    .rca_a(rca_a4), .rca_b(rca_b4), .rca_cin(rca_cin4), .rca_sum(rca_sum4), .rca_cout(rca_cout4),
    .out_valid(out_valid4), .out_ready(out_ready4), .sum(sum4), .cout(cout4), .busy(busy4));

  int vec = 0, errs = 0;
  logic [3:0] cin_seq;

  typedef struct {
    logic [15:0] a, b;
    logic        cin;
    logic [15:0] exp_sum;
    logic        exp_cout;
  } vec_t;
  vec_t tbl[6];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Presents operands for one edge; returns at the falling edge after the accept edge.
  task automatic start_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tc);
    @(negedge clk);
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    a = ta; b = tb_; cin = tc; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    cin_seq = '0;
    while (!out_valid && lat < 50) begin
      if (busy) cin_seq = {cin_seq[2:0], rca_cin};
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_op();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_after_release", 32'(out_valid), 32'd0);
    check("in_ready_after_release", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int          lat;
    logic [15:0] ra, rb, hs;
    logic        rc, hc;
    logic [16:0] model;

    tbl[0] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    tbl[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    tbl[3] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
    tbl[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    tbl[5] = '{16'hABCD, 16'h1234, 1'b1, 16'hBE02, 1'b0};

    // Reset state
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      start_op(tbl[i].a, tbl[i].b, tbl[i].cin);
      wait_done(lat);
      check($sformatf("tbl%0d_latency", i), 32'(lat), 32'd4);
      check($sformatf("tbl%0d_sum", i), 32'(sum), 32'(tbl[i].exp_sum));
      check($sformatf("tbl%0d_cout", i), 32'(cout), 32'(tbl[i].exp_cout));
      if (i == 1) check("carry_chain_rca_cin", 32'(cin_seq), 32'b0111);
      release_op();
    end

    // Random operands against a plain arithmetic model
    for (int i = 0; i < 30; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      model = 17'(ra) + 17'(rb) + 17'(rc);
      start_op(ra, rb, rc);
      wait_done(lat);
      check("rand_latency", 32'(lat), 32'd4);
      check("rand_sum", 32'(sum), 32'(model[15:0]));
      check("rand_cout", 32'(cout), 32'(model[16]));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      release_op();
    end

    // Back-pressure in DONE with a stray operand offer
    start_op(16'h1234, 16'h1111, 1'b0);
    wait_done(lat);
    hs = sum; hc = cout;
    check("bp_sum_first", 32'(hs), 32'h2345);
    a = 16'hDEAD; b = 16'hBEEF; cin = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_valid = (k == 1 || k == 3);
      @(posedge clk);
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_sum_stable", 32'(sum), 32'(hs));
      check("bp_cout_stable", 32'(cout), 32'(hc));
    end
    in_valid = 1'b0;
    release_op();
    start_op(16'h0102, 16'h0304, 1'b1);
    wait_done(lat);
    check("bp_next_sum", 32'(sum), 32'h0407);
    release_op();

    // Reset mid-RUN at idx=2
    start_op(16'hFFFF, 16'h0001, 1'b0);
    repeat (2) begin @(posedge clk); @(negedge clk); end
    check("mid_run_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_run_in_ready", 32'(in_ready), 32'd1);
    check("rst_run_busy", 32'(busy), 32'd0);
    check("rst_run_out_valid", 32'(out_valid), 32'd0);
    check("rst_run_sum", 32'(sum), 32'd0);
    check("rst_run_rca", 32'({rca_a, rca_b, rca_cin}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    start_op(16'h0F0F, 16'h00F1, 1'b0);
    wait_done(lat);
    check("post_rst_sum", 32'(sum), 32'h1000);
    check("post_rst_cout", 32'(cout), 32'd0);
    release_op();

    // WIDTH=4: single RUN cycle
    @(negedge clk);
    a4 = 4'h7; b4 = 4'h9; cin4 = 1'b0; in_valid4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid4 = 1'b0;
    check("w4_busy", 32'(busy4), 32'd1);
    check("w4_not_valid_yet", 32'(out_valid4), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("w4_out_valid", 32'(out_valid4), 32'd1);
    check("w4_sum", 32'(sum4), 32'h0);
    check("w4_cout", 32'(cout4), 32'd1);
    out_ready4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready4 = 1'b0;
    check("w4_in_ready", 32'(in_ready4), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
